// File: rtl/fifo_buf_pkg.sv
// Shared definitions for the fifo_buf FWFT FIFO: default sizes,
// {wr,rd} operation encodings and a depth helper.
package fifo_buf_pkg;

    localparam int B_DEF = 8;
    localparam int W_DEF = 2;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_RD  = 2'b01,
        OP_WR  = 2'b10,
        OP_RW  = 2'b11
    } op_e;

    function automatic int depth(input int w);
        return 2 ** w;
    endfunction

endpackage

// File: rtl/fifo_buf_if.sv
// Handshake bundle between a FIFO producer/consumer and fifo_buf.
// master: drives rd, wr, w_data; slave: drives empty, full, r_data
// and, with FIFO_STATUS_EN defined, count, ovf, udf.
interface fifo_if #(
    parameter int B = 8,
    parameter int W = 2
);

    logic         rd;
    logic         wr;
    logic [B-1:0] w_data;
    logic         empty;
    logic         full;
    logic [B-1:0] r_data;

`ifdef FIFO_STATUS_EN
    logic [W:0]   count;
    logic         ovf;
    logic         udf;

    modport master (
        output rd, wr, w_data,
        input  empty, full, r_data, count, ovf, udf
    );
    modport slave (
        input  rd, wr, w_data,
        output empty, full, r_data, count, ovf, udf
    );
`else
    modport master (
        output rd, wr, w_data,
        input  empty, full, r_data
    );
    modport slave (
        input  rd, wr, w_data,
        output empty, full, r_data
    );
`endif

endinterface

// File: rtl/fifo_buf_ctrl.sv
// fifo_ctrl: pointers, registered empty/full flags and optional status
// (FIFO_STATUS_EN: count, ovf, udf). Ports: clk, reset, rd, wr in;
// empty, full, wr_en, w_addr, r_addr out.
module fifo_ctrl
    import fifo_buf_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    output logic         empty,
    output logic         full,
    output logic         wr_en,
    output logic [W-1:0] w_addr,
    output logic [W-1:0] r_addr
`ifdef FIFO_STATUS_EN
    ,
    output logic [W:0]   count,
    output logic         ovf,
    output logic         udf
`endif
);

    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_nxt;
    logic [W-1:0] r_nxt;

    // Pointers wrap naturally at W bits.
    assign w_nxt  = w_ptr + 1'b1;
    assign r_nxt  = r_ptr + 1'b1;
    // A full FIFO still accepts a write when the same edge pops a word.
    assign wr_en  = wr & (~full | rd);
    assign w_addr = w_ptr;
    assign r_addr = r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            unique case (op_e'({wr, rd}))
                OP_NOP: ;
                OP_RD: begin
                    if (!empty) begin
                        r_ptr <= r_nxt;
                        full  <= 1'b0;
                        empty <= (r_nxt == w_ptr);
                    end
                end
                OP_WR: begin
                    if (!full) begin
                        w_ptr <= w_nxt;
                        empty <= 1'b0;
                        full  <= (w_nxt == r_ptr);
                    end
                end
                OP_RW: begin
                    // On empty only the write lands; otherwise the
                    // occupancy is unchanged so the flags hold.
                    if (empty) begin
                        w_ptr <= w_nxt;
                        empty <= 1'b0;
                    end else begin
                        w_ptr <= w_nxt;
                        r_ptr <= r_nxt;
                    end
                end
            endcase
        end
    end

`ifdef FIFO_STATUS_EN
    logic rd_en;

    assign rd_en = rd & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            count <= count + (W+1)'(wr_en) - (W+1)'(rd_en);
            ovf   <= ovf | (wr & ~rd & full);
            udf   <= udf | (rd & ~wr & empty);
        end
    end
`endif

endmodule

// File: rtl/fifo_buf.sv
// fifo_buf: first-word-fall-through FIFO of 2**W words x B bits.
// Ports: clk, reset (async, active-high), bus (fifo_if.slave).
// Optional status outputs enabled by FIFO_STATUS_EN.
module fifo_buf
    import fifo_buf_pkg::*;
#(
    parameter int B = B_DEF,
    parameter int W = W_DEF
) (
    input logic clk,
    input logic reset,
    fifo_if.slave bus
);

    localparam int DEPTH = depth(W);

    logic [B-1:0] mem [DEPTH];
    logic         wr_en;
    logic [W-1:0] w_addr;
    logic [W-1:0] r_addr;

    fifo_ctrl #(
        .W (W)
    ) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .rd     (bus.rd),
        .wr     (bus.wr),
        .empty  (bus.empty),
        .full   (bus.full),
        .wr_en  (wr_en),
        .w_addr (w_addr),
        .r_addr (r_addr)
`ifdef FIFO_STATUS_EN
        ,
        .count  (bus.count),
        .ovf    (bus.ovf),
        .udf    (bus.udf)
`endif
    );

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_addr] <= bus.w_data;
        end
    end

    assign bus.r_data = mem[r_addr];

endmodule
